// File: rtl/shift_pipe_param_if.sv
// ---------------------------------------------------------------------------
// shift_pipe_param_if
// Handshake bundle for the pipelined barrel shifter.
//
// Upstream (op request):
//   in_valid  op presented             in_ready  shifter accepts this cycle
//   in_data   operand (WIDTH)          in_shamt  shift amount (LOGW)
//   in_op     00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_tag    opaque id (TAG_W), returned with the result
// Downstream (result):
//   out_valid result valid             out_ready consumer accepts
//   out_data  shifted result (WIDTH)   out_tag   tag of this result
//   out_zero  out_data == 0, qualified by out_valid
//
// Modports: slave = shifter side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface shift_pipe_param_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int LOGW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LOGW-1:0]  in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero
    );

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero
    );
endinterface

// File: rtl/shift_pipe_param.sv
// ---------------------------------------------------------------------------
// shift_pipe_param
// Pipelined barrel shifter (SLL / SRL / SRA / optional ROR) for the ALU
// execute path. Stage k shifts by 2^k when shamt[k] is set, so an op takes
// LOGW = $clog2(WIDTH) register stages. Full valid/ready backpressure,
// 1 op/cycle throughput, bubbles collapse.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset; clears every stage
//   bus      shift_pipe_param_if.slave (in_* request side, out_* result side)
//
// Build option:
//   SHIFT_PIPE_ROTATE_EN  when defined, op 11 rotates right by shamt;
//                         otherwise op 11 returns the operand unchanged.
// ---------------------------------------------------------------------------
module shift_pipe_param #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    shift_pipe_param_if.slave   bus
);
    localparam int LOGW = $clog2(WIDTH);

    // Per-stage state: S0 .. S(LOGW-1)
    logic [LOGW-1:0]  r_vld;
    logic [WIDTH-1:0] r_data  [LOGW];
    logic [1:0]       r_op    [LOGW];
    logic [LOGW-1:0]  r_shamt [LOGW];
    logic [TAG_W-1:0] r_tag   [LOGW];
    logic             r_sign  [LOGW];

    logic [LOGW-1:0]  w_adv;

    // One stage's worth of shifting by a fixed amount.
    function automatic logic [WIDTH-1:0] f_stage_shift(
        input logic [WIDTH-1:0] data,
        input logic [1:0]       op,
        input logic             sign,
        input int unsigned      amt
    );
        logic [WIDTH-1:0] fill;
        // ones in the top amt bit positions
        fill = ~({WIDTH{1'b1}} >> amt);
        case (op)
            2'b00:   f_stage_shift = data << amt;
            2'b01:   f_stage_shift = data >> amt;
            2'b10:   f_stage_shift = (data >> amt) | (sign ? fill : '0);
`ifdef SHIFT_PIPE_ROTATE_EN
            default: f_stage_shift = (data >> amt) | (data << (WIDTH - amt));
`else
            default: f_stage_shift = data;
`endif
        endcase
    endfunction

    // A stage may advance when it, or any stage downstream of it, is empty,
    // or when the consumer takes the last stage. This is the unrolled form of
    // adv[k] = !v[k] | adv[k+1] and avoids a combinational chain through w_adv.
    always_comb begin
        w_adv = '0;
        for (int k = 0; k < LOGW; k++) begin
            w_adv[k] = bus.out_ready | (|(~r_vld >> k));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            for (int k = 0; k < LOGW; k++) begin
                r_data[k]  <= '0;
                r_op[k]    <= '0;
                r_shamt[k] <= '0;
                r_tag[k]   <= '0;
                r_sign[k]  <= 1'b0;
            end
        end else begin
            // S0: capture the op, apply the 2^0 step, latch the SRA fill bit
            if (w_adv[0]) begin
                r_vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    r_data[0]  <= bus.in_shamt[0]
                                ? f_stage_shift(bus.in_data, bus.in_op, bus.in_data[WIDTH-1], 1)
                                : bus.in_data;
                    r_op[0]    <= bus.in_op;
                    r_shamt[0] <= bus.in_shamt;
                    r_tag[0]   <= bus.in_tag;
                    r_sign[0]  <= bus.in_data[WIDTH-1];
                end
            end
            // S1 .. S(LOGW-1): apply the 2^k step from the previous stage
            for (int k = 1; k < LOGW; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    if (r_vld[k-1]) begin
                        r_data[k]  <= r_shamt[k-1][k]
                                    ? f_stage_shift(r_data[k-1], r_op[k-1], r_sign[k-1], 1 << k)
                                    : r_data[k-1];
                        r_op[k]    <= r_op[k-1];
                        r_shamt[k] <= r_shamt[k-1];
                        r_tag[k]   <= r_tag[k-1];
                        r_sign[k]  <= r_sign[k-1];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = r_vld[LOGW-1];
    assign bus.out_data  = r_data[LOGW-1];
    assign bus.out_tag   = r_tag[LOGW-1];
    assign bus.out_zero  = (r_data[LOGW-1] == '0);

endmodule

// File: tb/tb_shift_pipe_param.sv
// ---------------------------------------------------------------------------
// tb_shift_pipe_param
// Scoreboard bench for shift_pipe_param (WIDTH=32, TAG_W=4, LOGW=5).
// An input monitor pushes the reference result of every accepted op; an
// output monitor pops and compares on every result transfer.
// ---------------------------------------------------------------------------
module tb_shift_pipe_param;
    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int LOGW  = 5;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    logic ready_cmd;
    logic rand_ready;
    logic rnd_bit;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t sbq[$];
    int   pop_log[$];

    logic             hold_prev = 1'b0;
    logic [WIDTH-1:0] hold_data;
    logic [TAG_W-1:0] hold_tag;

    shift_pipe_param_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    shift_pipe_param #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    assign bus.out_ready = rand_ready ? rnd_bit : ready_cmd;

    // Reference: plain shift arithmetic on the whole operand
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                   input int s, input logic [1:0] op);
        logic [2*WIDTH-1:0] w;
        case (op)
            2'b00: return d << s;
            2'b01: return d >> s;
            2'b10: return $signed(d) >>> s;
            default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
                w = {d, d} >> s;
                return w[WIDTH-1:0];
`else
                w = '0;
                return d;
`endif
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Input monitor: record every accepted op
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && bus.in_valid && bus.in_ready) begin
            e.data = ref_shift(bus.in_data, int'(bus.in_shamt), bus.in_op);
            e.tag  = bus.in_tag;
            sbq.push_back(e);
        end
    end

    // Output monitor: compare every result transfer, check stall stability
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            hold_prev = 1'b0;
        end else begin
            if (bus.out_valid && !bus.out_ready) begin
                if (hold_prev) begin
                    chk("hold_data", bus.out_data, hold_data);
                    chk("hold_tag", bus.out_tag, hold_tag);
                end
                hold_prev = 1'b1;
                hold_data = bus.out_data;
                hold_tag  = bus.out_tag;
            end else begin
                hold_prev = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                pop_log.push_back(cyc);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual data=%0h tag=%0h required none",
                             bus.out_data, bus.out_tag);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_tag", bus.out_tag, e.tag);
                    chk("out_zero", bus.out_zero, (e.data == '0));
                end
            end
        end
    end

    // Present one op and hold it until accepted; returns the stall cycles.
    task automatic send(input logic [WIDTH-1:0] d, input logic [LOGW-1:0] s,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag,
                        output int waits);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_op    = op;
        bus.in_tag   = tag;
        waits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                ok = 1;
                @(posedge clock);
                #1;
                break;
            end
            @(posedge clock);
            #1;
            waits++;
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd1, 64'd0);
    endtask

    // Called right after send(): edges from accept to first visible out_valid
    task automatic lat_check(input string nm);
        int a = cyc;
        int e = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.out_valid) begin
                e = cyc - a;
                break;
            end
        end
        chk(nm, e, LOGW - 1);
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sbq.size() != 0; i++) @(negedge clock);
        chk("drain_empty", sbq.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int w;
        int acc;
        bit took;
        logic [3:0] t;

        reset_n      = 1'b0;
        ready_cmd    = 1'b1;
        rand_ready   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_shamt = '0;
        bus.in_op    = '0;
        bus.in_tag   = '0;

        #2;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_out_tag", bus.out_tag, 0);
        chk("reset_out_zero", bus.out_zero, 1);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // SRA fill and first-op latency
        send(32'h8000_0000, 5'd16, 2'b10, 4'h1, w);
        lat_check("latency_first");
        send(32'h7FFF_0000, 5'd16, 2'b10, 4'h2, w);
        drain();

        // Extreme and zero shift amounts, out_zero both ways
        send(32'h0000_0001, 5'd31, 2'b00, 4'h3, w);
        send(32'h8000_0000, 5'd31, 2'b01, 4'h4, w);
        send(32'hDEAD_BEEF, 5'd0,  2'b00, 4'h5, w);
        send(32'h0000_0001, 5'd0,  2'b00, 4'h6, w);
        send(32'h0000_0001, 5'd1,  2'b01, 4'h7, w);
        send(32'hC000_0000, 5'd0,  2'b10, 4'h8, w);
        drain();

        // Back-to-back: 8 ops, no input stall, 8 consecutive results
        pop_log.delete();
        for (int i = 0; i < 8; i++) begin
            send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'(i), w);
            chk("b2b_in_ready", w, 0);
        end
        drain();
        chk("b2b_count", pop_log.size(), 8);
        for (int i = 1; i < pop_log.size(); i++)
            chk("b2b_consecutive", pop_log[i] - pop_log[i-1], 1);

        // Backpressure: consumer stalls 10 cycles while ops keep coming
        ready_cmd = 1'b0;
        acc = 0;
        t = 4'h0;
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        bus.in_shamt = 5'($urandom_range(0, 31));
        bus.in_op    = 2'($urandom_range(0, 3));
        bus.in_tag   = t;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            took = bus.in_ready;
            @(posedge clock);
            #1;
            if (took) begin
                acc++;
                t = t + 4'h1;
                bus.in_data  = $urandom;
                bus.in_shamt = 5'($urandom_range(0, 31));
                bus.in_op    = 2'($urandom_range(0, 3));
                bus.in_tag   = t;
            end
        end
        @(negedge clock);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        chk("stall_accepted", acc, LOGW);
        @(posedge clock);
        #1;
        ready_cmd = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            took = bus.in_ready;
            @(posedge clock);
            #1;
            if (took) break;
        end
        bus.in_valid = 1'b0;
        drain();

        // Rotate (or pass-through when rotate is not built)
        send(32'h0000_00F1, 5'd4, 2'b11, 4'h9, w);
        send(32'h1234_5678, 5'd31, 2'b11, 4'hA, w);
        drain();

        // Reset with 3 ops in flight
        send(32'h1111_1111, 5'd1, 2'b00, 4'h1, w);
        send(32'h2222_2222, 5'd2, 2'b01, 4'h2, w);
        send(32'h3333_3333, 5'd3, 2'b10, 4'h3, w);
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_out_zero", bus.out_zero, 1);
        sbq.delete();
        pop_log.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hFFFF_FFFF;
        bus.in_tag   = 4'hF;
        repeat (2) @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        reset_n = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("post_reset_quiet", pop_log.size(), 0);
        send(32'h0000_0F00, 5'd8, 2'b01, 4'h5, w);
        lat_check("latency_after_reset");
        drain();

        // Randomized traffic with random consumer backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
            send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'(i), w);
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
